// File: rtl/hex_word_formatter.sv
// hex_word_formatter
//   Takes whole binary words over a valid/ready handshake and streams them
//   byte by byte as printable ASCII hex text, e.g. "0xDEADBEEF\r\n", into a
//   byte-wide transmitter handshake (serial_transmitter).
//
// Parameters
//   WORD_WIDTH : input word width, multiple of 4, 4..64
//   PREFIX_EN  : 1 -> emit "0x" before the digits
//   UPPERCASE  : 1 -> hex letters A-F, 0 -> a-f
//
// Ports
//   clock             : single clock, all state changes on its rising edge
//   reset             : asynchronous, active-low
//   word_data         : word to print
//   word_valid        : producer has a word
//   word_ready        : block can accept a word (IDLE, out of reset)
//   tx_data           : current ASCII byte to the transmitter
//   tx_data_available : tx_data is valid
//   tx_ready          : transmitter takes the byte on this edge
//   busy              : a word is being emitted
module hex_word_formatter #(
    parameter int WORD_WIDTH = 32,
    parameter bit PREFIX_EN  = 1'b1,
    parameter bit UPPERCASE  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_data_available,
    input  logic                  tx_ready,
    output logic                  busy
);

    localparam int N  = WORD_WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);
    localparam logic [7:0]    ALPHA_BASE = UPPERCASE ? 8'h41 : 8'h61;

    typedef enum logic [2:0] {
        IDLE,
        PFX0,
        PFX1,
        DIGIT,
        CR,
        LF
    } state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic                  out_en;   // low through reset and until the first edge after release
    logic                  accept;
    logic                  consume;
    logic [3:0]            nib;
    logic [7:0]            nib_ascii;

    assign accept            = word_valid && word_ready;
    assign consume           = tx_data_available && tx_ready;
    assign busy              = (state != IDLE);
    assign tx_data_available = busy;
    assign word_ready        = out_en && (state == IDLE);

    // Digits leave MSB nibble first; the shift register always holds the
    // nibble being presented at its top.
    assign nib = shreg[WORD_WIDTH-1 -: 4];

    always_comb begin
        nib_ascii = 8'h00;
        if (nib < 4'd10)
            nib_ascii = 8'h30 + {4'h0, nib};
        else
            nib_ascii = ALPHA_BASE + {4'h0, nib} - 8'd10;
    end

    // Byte presented is purely a function of state, so holding state while
    // tx_ready is low holds the byte without any extra register.
    always_comb begin
        tx_data = 8'h00;
        case (state)
            PFX0:    tx_data = 8'h30;
            PFX1:    tx_data = 8'h78;
            DIGIT:   tx_data = nib_ascii;
            CR:      tx_data = 8'h0D;
            LF:      tx_data = 8'h0A;
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            out_en <= 1'b0;
        end else begin
            out_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= word_data;
                        cnt   <= LAST_DIGIT;
                        state <= PREFIX_EN ? PFX0 : DIGIT;
                    end
                end
                PFX0: if (consume) state <= PFX1;
                PFX1: if (consume) state <= DIGIT;
                DIGIT: begin
                    if (consume) begin
                        shreg <= shreg << 4;
                        // Counter is never decremented past zero; zero marks the last digit.
                        if (cnt == '0)
                            state <= CR;
                        else
                            cnt <= cnt - 1'b1;
                    end
                end
                CR: if (consume) state <= LF;
                LF: if (consume) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_word_formatter.sv
module tb_hex_word_formatter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // DUT A: default parameters
    logic [31:0] a_word_data = '0;
    logic        a_word_valid = 1'b0;
    logic        a_word_ready;
    logic [7:0]  a_tx_data;
    logic        a_tx_data_available;
    logic        a_tx_ready = 1'b0;
    logic        a_busy;

    // DUT B: 8-bit, no prefix, lowercase
    logic [7:0]  b_word_data = '0;
    logic        b_word_valid = 1'b0;
    logic        b_word_ready;
    logic [7:0]  b_tx_data;
    logic        b_tx_data_available;
    logic        b_tx_ready = 1'b0;
    logic        b_busy;

    hex_word_formatter dut_a (
        .clock(clock), .reset(reset),
        .word_data(a_word_data), .word_valid(a_word_valid), .word_ready(a_word_ready),
        .tx_data(a_tx_data), .tx_data_available(a_tx_data_available),
        .tx_ready(a_tx_ready), .busy(a_busy)
    );

    hex_word_formatter #(.WORD_WIDTH(8), .PREFIX_EN(1'b0), .UPPERCASE(1'b0)) dut_b (
        .clock(clock), .reset(reset),
        .word_data(b_word_data), .word_valid(b_word_valid), .word_ready(b_word_ready),
        .tx_data(b_tx_data), .tx_data_available(b_tx_data_available),
        .tx_ready(b_tx_ready), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    // Reference formatter: pushes the full expected byte sequence of one word.
    function automatic void push_exp(input bit sel, input logic [63:0] w, input int width,
                                     input bit pfx, input bit up);
        logic [7:0] seq[$];
        logic [3:0] n;
        if (pfx) begin seq.push_back(8'h30); seq.push_back(8'h78); end
        for (int i = width/4 - 1; i >= 0; i--) begin
            n = w[i*4 +: 4];
            if (n < 10) seq.push_back(8'h30 + 8'(n));
            else        seq.push_back((up ? 8'h41 : 8'h61) + 8'(n) - 8'd10);
        end
        seq.push_back(8'h0D);
        seq.push_back(8'h0A);
        foreach (seq[i]) begin
            if (sel) exp_b.push_back(seq[i]);
            else     exp_a.push_back(seq[i]);
        end
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (a_word_ready !== 1'b0) begin errors++; $display("FAIL reset_word_ready got %b expected 0", a_word_ready); end
        checks++;
        if (a_tx_data_available !== 1'b0 || a_busy !== 1'b0) begin
            errors++; $display("FAIL reset_avail_busy got %b%b expected 00", a_tx_data_available, a_busy);
        end
        checks++;
        if (a_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h expected 00", a_tx_data); end
        checks++;
        if (b_word_ready !== 1'b0) begin errors++; $display("FAIL reset_b_word_ready got %b expected 0", b_word_ready); end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (a_word_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++; $display("FAIL release_idle got ready=%b busy=%b expected 1 0", a_word_ready, a_busy);
        end
    endtask

    task automatic test_deadbeef();
        int n = 0;
        bit acc;
        logic [7:0] e;
        @(posedge clock); #1;
        a_word_data = 32'hDEADBEEF; a_word_valid = 1'b1; a_tx_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            acc = a_word_valid && a_word_ready;
            if (acc) push_exp(1'b0, 64'(a_word_data), 32, 1'b1, 1'b1);
            if (a_tx_data_available && a_tx_ready) begin
                n++;
                checks++;
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL deadbeef_extra got %h expected no byte", a_tx_data);
                end else begin
                    e = exp_a.pop_front();
                    if (a_tx_data !== e) begin errors++; $display("FAIL deadbeef_byte%0d got %h expected %h", n, a_tx_data, e); end
                end
            end
            @(posedge clock); #1;
            // Changing word_data after acceptance must not affect the output.
            if (acc) begin a_word_valid = 1'b0; a_word_data = 32'h13572468; end
        end
        checks++;
        if (n != 12 || exp_a.size() != 0) begin errors++; $display("FAIL deadbeef_count got %0d expected 12", n); end
        checks++;
        if (a_tx_data_available !== 1'b0 || a_word_ready !== 1'b1) begin
            errors++; $display("FAIL deadbeef_end got avail=%b ready=%b expected 0 1", a_tx_data_available, a_word_ready);
        end
        exp_a.delete();
    endtask

    task automatic test_stall();
        int n = 0;
        int stalls = 0;
        bit acc;
        logic [7:0] e;
        @(posedge clock); #1;
        a_word_data = 32'hDEADBEEF; a_word_valid = 1'b1; a_tx_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            acc = a_word_valid && a_word_ready;
            if (acc) push_exp(1'b0, 64'(a_word_data), 32, 1'b1, 1'b1);
            if (!a_tx_ready) begin
                checks++;
                if (a_tx_data !== 8'h78 || a_tx_data_available !== 1'b1) begin
                    errors++; $display("FAIL stall_hold got %h avail=%b expected 78 avail=1", a_tx_data, a_tx_data_available);
                end
            end
            if (a_tx_data_available && a_tx_ready) begin
                n++;
                checks++;
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL stall_extra got %h expected no byte", a_tx_data);
                end else begin
                    e = exp_a.pop_front();
                    if (a_tx_data !== e) begin errors++; $display("FAIL stall_byte%0d got %h expected %h", n, a_tx_data, e); end
                end
            end
            @(posedge clock); #1;
            if (acc) a_word_valid = 1'b0;
            if (a_tx_data == 8'h78 && stalls < 3) begin a_tx_ready = 1'b0; stalls++; end
            else a_tx_ready = 1'b1;
        end
        checks++;
        if (n != 12 || stalls != 3 || exp_a.size() != 0) begin
            errors++; $display("FAIL stall_count got bytes=%0d stalls=%0d expected 12 3", n, stalls);
        end
        exp_a.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[2] = '{32'h00000000, 32'h0123ABCD};
        int idx = 0;
        int n = 0;
        int lf_cyc = -1;
        int acc_cyc[2] = '{-1, -1};
        bit acc;
        logic [7:0] e;
        @(posedge clock); #1;
        a_word_data = w[0]; a_word_valid = 1'b1; a_tx_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            checks++;
            if (a_busy && a_word_ready) begin errors++; $display("FAIL b2b_ready_busy got ready=1 expected 0 at cycle %0d", c); end
            acc = a_word_valid && a_word_ready;
            if (acc) begin push_exp(1'b0, 64'(a_word_data), 32, 1'b1, 1'b1); acc_cyc[idx] = c; end
            if (a_tx_data_available && a_tx_ready) begin
                n++;
                if (a_tx_data == 8'h0A && lf_cyc < 0) lf_cyc = c;
                checks++;
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL b2b_extra got %h expected no byte", a_tx_data);
                end else begin
                    e = exp_a.pop_front();
                    if (a_tx_data !== e) begin errors++; $display("FAIL b2b_byte%0d got %h expected %h", n, a_tx_data, e); end
                end
            end
            @(posedge clock); #1;
            if (acc) begin
                idx++;
                if (idx < 2) a_word_data = w[idx];
                else a_word_valid = 1'b0;
            end
        end
        checks++;
        if (n != 24 || exp_a.size() != 0) begin errors++; $display("FAIL b2b_count got %0d expected 24", n); end
        checks++;
        if (lf_cyc < 0 || acc_cyc[1] != lf_cyc + 1) begin
            errors++; $display("FAIL b2b_accept_cycle got %0d expected %0d", acc_cyc[1], lf_cyc + 1);
        end
        exp_a.delete();
    endtask

    task automatic test_reset_mid_word();
        int n = 0;
        bit acc;
        bit done = 1'b0;
        logic [7:0] e;
        @(posedge clock); #1;
        a_word_data = 32'hCAFEF00D; a_word_valid = 1'b1; a_tx_ready = 1'b1;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clock);
            acc = a_word_valid && a_word_ready;
            if (acc) push_exp(1'b0, 64'(a_word_data), 32, 1'b1, 1'b1);
            if (a_tx_data_available && a_tx_ready) begin
                n++;
                checks++;
                e = (exp_a.size() != 0) ? exp_a.pop_front() : 8'hXX;
                if (a_tx_data !== e) begin errors++; $display("FAIL rst_pre_byte%0d got %h expected %h", n, a_tx_data, e); end
            end
            @(posedge clock); #1;
            if (acc) a_word_valid = 1'b0;
            if (n == 5) begin
                #2 reset = 1'b0;
                #1;
                checks++;
                if (a_tx_data_available !== 1'b0 || a_busy !== 1'b0 || a_tx_data !== 8'h00 || a_word_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_async got avail=%b busy=%b data=%h ready=%b expected 0 0 00 0",
                             a_tx_data_available, a_busy, a_tx_data, a_word_ready);
                end
                done = 1'b1;
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL rst_timeout got %0d bytes expected 5", n); end
        exp_a.delete();
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        @(posedge clock); #1;
        a_word_data = 32'h00000001; a_word_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            acc = a_word_valid && a_word_ready;
            if (acc) push_exp(1'b0, 64'(a_word_data), 32, 1'b1, 1'b1);
            if (a_tx_data_available && a_tx_ready) begin
                n++;
                checks++;
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL rst_post_extra got %h expected no byte", a_tx_data);
                end else begin
                    e = exp_a.pop_front();
                    if (a_tx_data !== e) begin errors++; $display("FAIL rst_post_byte%0d got %h expected %h", n, a_tx_data, e); end
                end
            end
            @(posedge clock); #1;
            if (acc) a_word_valid = 1'b0;
        end
        checks++;
        if (n != 12 || exp_a.size() != 0) begin errors++; $display("FAIL rst_post_count got %0d expected 12", n); end
        exp_a.delete();
    endtask

    task automatic test_narrow_lower();
        int n = 0;
        bit acc;
        logic [7:0] e;
        @(posedge clock); #1;
        b_word_data = 8'hA5; b_word_valid = 1'b1; b_tx_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            acc = b_word_valid && b_word_ready;
            if (acc) push_exp(1'b1, 64'(b_word_data), 8, 1'b0, 1'b0);
            if (b_tx_data_available && b_tx_ready) begin
                n++;
                checks++;
                if (exp_b.size() == 0) begin
                    errors++; $display("FAIL narrow_extra got %h expected no byte", b_tx_data);
                end else begin
                    e = exp_b.pop_front();
                    if (b_tx_data !== e) begin errors++; $display("FAIL narrow_byte%0d got %h expected %h", n, b_tx_data, e); end
                end
            end
            @(posedge clock); #1;
            if (acc) b_word_valid = 1'b0;
        end
        checks++;
        if (n != 4 || exp_b.size() != 0) begin errors++; $display("FAIL narrow_count got %0d expected 4", n); end
        checks++;
        if (b_busy !== 1'b0 || b_word_ready !== 1'b1) begin
            errors++; $display("FAIL narrow_end got busy=%b ready=%b expected 0 1", b_busy, b_word_ready);
        end
    endtask

    initial begin
        test_reset();
        test_deadbeef();
        test_stall();
        test_back_to_back();
        test_reset_mid_word();
        test_narrow_lower();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_word_formatter.md
# hex_word_formatter

Converts a binary word into printable ASCII hex text, for example "0xDEADBEEF\r\n", and streams it one byte at a time into the UART transmitter. It sits directly upstream of `serial_transmitter`:
- its `tx_data` / `tx_data_available` outputs drive that block's inputs;
- it consumes that block's `tx_ready` output.

Debug and telemetry logic hands it whole words through a valid/ready handshake and never deals with individual characters.

## Interface
- `WORD_WIDTH`, default 32: input word width in bits. Must be a multiple of 4, range 4..64.
- `PREFIX_EN`, default 1: when 1, emit "0x" before the digits; when 0, emit no prefix.
- `UPPERCASE`, default 1: hex letters are A-F when 1, a-f when 0.
- `clock` input 1: the single clock, 48 MHz HFOSC; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `word_data` input WORD_WIDTH: word to print.
- `word_valid` input 1: producer has a word.
- `word_ready` output 1: block can accept a word.
- `tx_data` output 8: current ASCII byte to the transmitter.
- `tx_data_available` output 1: `tx_data` is valid.
- `tx_ready` input 1: transmitter can take a byte.
- `busy` output 1: a word is being emitted (state ≠ IDLE).

## Operation
- Derived values:
  - N = WORD_WIDTH/4 digits.
  - Bytes per word = N + 2 + 2·PREFIX_EN.
- States: IDLE, PFX0 ('0', 0x30), PFX1 ('x', 0x78), DIGIT, CR (0x0D), LF (0x0A).
- IDLE:
  - `word_ready`=1, `tx_data_available`=0, `tx_data`=0x00.
  - On `word_valid`&&`word_ready`: latch `word_data` into an internal shift register and load the digit counter with N-1.
  - Next state is PFX0 if PREFIX_EN, else DIGIT.
  - `word_data` changes after acceptance have no effect.
- All non-IDLE states:
  - `word_ready`=0, `busy`=1, `tx_data_available`=1.
  - `tx_data` is a combinational function of state and the top nibble of the shift register.
- Byte handshake: a byte is consumed on a rising edge where `tx_data_available`&&`tx_ready`. Only then does the state advance.
- `tx_ready` low: state, `tx_data` and `tx_data_available` hold unchanged (no retraction, no byte change).
- Transitions on each consumed byte:
  - PFX0→PFX1, PFX1→DIGIT.
  - DIGIT: shift the register left by 4 and decrement the counter. When the counter was 0, go to CR instead.
  - CR→LF, LF→IDLE.
- Digits are emitted MSB nibble first. Nibble n maps to:
  - 0..9 → 0x30+n;
  - 10..15 → (UPPERCASE ? 0x41 : 0x61)+n-10.
- Counter width is max(1, clog2(N)). There is no wrap: the counter is only decremented while nonzero.

## Timing
- Reset values: `word_ready`=0 while reset is asserted, then 1 (IDLE) from the first cycle after release. `tx_data_available`=0, `tx_data`=0x00, `busy`=0.
- Reset asserted mid-word: outputs take their reset values immediately (asynchronously) and the partial word is discarded. No CR/LF is emitted for it.
- Latency: word accepted at edge k → first byte presented with `tx_data_available`=1 in the cycle after edge k.
- Throughput with `tx_ready` held high: one byte per cycle.
  - The real transmitter drops `tx_ready` for about 10 bit times per byte; this block simply waits.
- Back-to-back words:
  - LF consumed at edge k → IDLE in cycle k+1 → next word accepted at edge k+1.
  - Minimum one idle cycle between words.
- `word_valid` high while busy: not accepted. The producer must hold it.

## Test plan
- Default parameters, word 0xDEADBEEF, `tx_ready`=1 → exactly 12 bytes: 30 78 44 45 41 44 42 45 45 46 0D 0A, then `tx_data_available`=0 and `word_ready`=1.
- Same word, `tx_ready` forced 0 for 3 cycles while 0x78 is presented → `tx_data` stays 0x78 and `tx_data_available` stays 1 throughout; the next byte is 0x44 only after `tx_ready` returns.
- `word_valid` held high with 0x00000000 then 0x0123ABCD → "0x00000000\r\n" then "0x0123ABCD\r\n"; the second word is accepted exactly one cycle after the first LF is consumed, with no lost or duplicated byte.
- Reset asserted asynchronously (mid-cycle) after 5 bytes of 0xCAFEF00D → `tx_data_available` falls without waiting for a clock edge. After release, the next word 0x1 prints "0x00000001\r\n" from its first byte.
- WORD_WIDTH=8, PREFIX_EN=0, UPPERCASE=0, word 0xA5 → bytes 61 35 0D 0A.
- Integration: connect to `serial_transmitter`, print 0x12345678 → decode of the UART line shows "0x12345678\r\n" at 9600 baud.
